// File: rtl/bldc_pkg.sv
// Shared encodings for the BLDC commutator: phase states, fault codes and the
// hall-to-gate commutation tables.
package bldc_pkg;

    localparam logic [1:0] PH_OFF  = 2'd0;
    localparam logic [1:0] PH_DT   = 2'd1;
    localparam logic [1:0] PH_HIGH = 2'd2;
    localparam logic [1:0] PH_LOW  = 2'd3;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_HALL = 2'b01;
    localparam logic [1:0] FC_OCP  = 2'b10;

    localparam logic [2:0] HALL_ILL_LO = 3'b000;
    localparam logic [2:0] HALL_ILL_HI = 3'b111;

    // One table entry: {hi mask, lo mask}, bit 2 = phase A, bit 0 = phase C.
    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
    } comm_t;

    localparam logic [5:0] FWD_100 = 6'b100_001;
    localparam logic [5:0] FWD_110 = 6'b010_001;
    localparam logic [5:0] FWD_010 = 6'b010_100;
    localparam logic [5:0] FWD_011 = 6'b001_100;
    localparam logic [5:0] FWD_001 = 6'b001_010;
    localparam logic [5:0] FWD_101 = 6'b100_010;

    localparam logic [5:0] REV_100 = 6'b001_100;
    localparam logic [5:0] REV_110 = 6'b001_010;
    localparam logic [5:0] REV_010 = 6'b100_010;
    localparam logic [5:0] REV_011 = 6'b100_001;
    localparam logic [5:0] REV_001 = 6'b010_001;
    localparam logic [5:0] REV_101 = 6'b010_100;

    // Illegal sectors fall through to all-off.
    function automatic comm_t comm_lookup(input logic [2:0] sector, input logic dir);
        comm_t c;
        c = '0;
        case (sector)
            3'b100:  c = dir ? FWD_100 : REV_100;
            3'b110:  c = dir ? FWD_110 : REV_110;
            3'b010:  c = dir ? FWD_010 : REV_010;
            3'b011:  c = dir ? FWD_011 : REV_011;
            3'b001:  c = dir ? FWD_001 : REV_001;
            3'b101:  c = dir ? FWD_101 : REV_101;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bldc_phase_dt.sv
// One half-bridge phase: OFF/DT/HIGH/LOW state machine with dead-time counter
// and registered, PWM-gated gate outputs.
module bldc_phase_dt
    import bldc_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic            pwm,
    input  logic [DT_W-1:0] dead_time,
    output logic            gate_hi,
    output logic            gate_lo
);

    localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

    logic [1:0]      state_reg, state_next;
    logic [1:0]      tgt_reg, tgt_next;
    logic [DT_W-1:0] cnt_reg, cnt_next;

    // Loading dead_time-1 keeps the phase in DT for exactly dead_time cycles.
    always_comb begin
        state_next = state_reg;
        tgt_next   = tgt_reg;
        cnt_next   = cnt_reg;
        if (req == PH_OFF) begin
            state_next = PH_OFF;
        end else if (state_reg == PH_DT) begin
            if (req != tgt_reg) begin
                if (dead_time == '0) begin
                    state_next = req;
                end else begin
                    tgt_next = req;
                    cnt_next = dead_time - CNT_ONE;
                end
            end else if (cnt_reg == '0) begin
                state_next = tgt_reg;
            end else begin
                cnt_next = cnt_reg - CNT_ONE;
            end
        end else if (req != state_reg) begin
            if (dead_time == '0) begin
                state_next = req;
            end else begin
                state_next = PH_DT;
                tgt_next   = req;
                cnt_next   = dead_time - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= PH_OFF;
            tgt_reg   <= PH_OFF;
            cnt_reg   <= '0;
            gate_hi   <= 1'b0;
            gate_lo   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            cnt_reg   <= cnt_next;
            gate_hi   <= (state_next == PH_HIGH) & pwm;
            gate_lo   <= (state_next == PH_LOW);
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Hall-sensor BLDC commutator: input sync, hall debounce, request priority,
// latched faults, stall timer and three dead-time phase drivers.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DT_W    = 8,
    parameter int DB_W    = 4,
    parameter int STALL_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         hall,
    input  logic               dir,
    input  logic               brake,
    input  logic               i_limit,
    input  logic               pwm,
    input  logic [DT_W-1:0]    dead_time,
    input  logic [DB_W-1:0]    db_len,
    input  logic               fault_clr,
    output logic [2:0]         gate_hi,
    output logic [2:0]         gate_lo,
    output logic [2:0]         sector,
    output logic               hall_edge,
    output logic               stall,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [DB_W-1:0]    RUN_ONE   = DB_W'(1);
    localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

    logic [2:0]         hall_s1_reg, hall_s2_reg, hall_last_reg;
    logic               brake_s1_reg, brake_s2_reg;
    logic               ilim_s1_reg, ilim_s2_reg;
    logic [DB_W-1:0]    run_reg, run_next;
    logic               accept;
    logic [2:0]         sector_reg;
    logic               seen_reg;
    logic               hall_edge_reg;
    logic [2:0][1:0]    req_reg, req_next, phase_req;
    logic [1:0]         fault_code_reg;
    logic               illegal_now;
    logic               force_off;
    logic [STALL_W-1:0] timer_reg, timer_next;
    logic               stall_reg;
    comm_t              tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_s1_reg  <= '0;
            hall_s2_reg  <= '0;
            brake_s1_reg <= 1'b0;
            brake_s2_reg <= 1'b0;
            ilim_s1_reg  <= 1'b0;
            ilim_s2_reg  <= 1'b0;
        end else begin
            hall_s1_reg  <= hall;
            hall_s2_reg  <= hall_s1_reg;
            brake_s1_reg <= brake;
            brake_s2_reg <= brake_s1_reg;
            ilim_s1_reg  <= i_limit;
            ilim_s2_reg  <= ilim_s1_reg;
        end
    end

    // run_next counts extra cycles the synchronised hall has been steady,
    // so run_next >= db_len means db_len+1 stable cycles.
    always_comb begin
        run_next = '0;
        if (hall_s2_reg == hall_last_reg)
            run_next = (run_reg == '1) ? run_reg : run_reg + RUN_ONE;
    end

    assign accept = (run_next >= db_len) && (hall_s2_reg != sector_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hall_last_reg <= '0;
            run_reg       <= '0;
            sector_reg    <= '0;
            seen_reg      <= 1'b0;
            hall_edge_reg <= 1'b0;
        end else begin
            hall_last_reg <= hall_s2_reg;
            run_reg       <= run_next;
            hall_edge_reg <= accept;
            if (accept) begin
                sector_reg <= hall_s2_reg;
                seen_reg   <= 1'b1;
            end
        end
    end

    // The reset value 000 is not an accepted sector and must not trip a fault.
    assign illegal_now = seen_reg &&
                         ((sector_reg == HALL_ILL_LO) || (sector_reg == HALL_ILL_HI));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_code_reg <= FC_NONE;
        end else if (fault_code_reg == FC_NONE) begin
            if (illegal_now)
                fault_code_reg <= FC_HALL;
            else if (ilim_s2_reg)
                fault_code_reg <= FC_OCP;
        end else if (fault_clr) begin
            if ((fault_code_reg == FC_HALL) && !illegal_now)
                fault_code_reg <= FC_NONE;
            else if ((fault_code_reg == FC_OCP) && !ilim_s2_reg)
                fault_code_reg <= FC_NONE;
        end
    end

    // Fault and over-current bypass the request register so they cut the
    // gates one cycle sooner than a commutation change.
    assign force_off = (fault_code_reg != FC_NONE) || ilim_s2_reg;
    assign tbl       = comm_lookup(sector_reg, dir);

    always_comb begin
        timer_next = timer_reg;
        if (accept)
            timer_next = '0;
        else if (!brake_s2_reg && (fault_code_reg == FC_NONE) && (timer_reg != '1))
            timer_next = timer_reg + STALL_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg <= '0;
            stall_reg <= 1'b0;
            req_reg   <= '0;
        end else begin
            timer_reg <= timer_next;
            stall_reg <= (timer_next == '1);
            req_reg   <= req_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_phase
            assign req_next[gi]  = brake_s2_reg ? PH_LOW  :
                                   tbl.hi[gi]   ? PH_HIGH :
                                   tbl.lo[gi]   ? PH_LOW  : PH_OFF;
            assign phase_req[gi] = force_off ? PH_OFF : req_reg[gi];

            bldc_phase_dt #(
                .DT_W(DT_W)
            ) u_phase (
                .clk      (clk),
                .rst      (rst),
                .req      (phase_req[gi]),
                .pwm      (pwm),
                .dead_time(dead_time),
                .gate_hi  (gate_hi[gi]),
                .gate_lo  (gate_lo[gi])
            );
        end
    endgenerate

    assign sector     = sector_reg;
    assign hall_edge  = hall_edge_reg;
    assign stall      = stall_reg;
    assign fault_code = fault_code_reg;
    assign fault      = (fault_code_reg != FC_NONE);

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Clocked, parametrised hall-sensor commutation block for a 3-phase BLDC bridge driving six gate outputs.
- Adds input synchronisation, hall debounce, per-phase dead-time insertion, PWM gating of the high sides, latched fault handling and stall detection.
- Sits between the hall/current-limit pins and the gate drivers; PWM comes from an external generator.

Parameters:
- DT_W, 8: width of the dead-time count; dead time is in clk cycles.
- DB_W, 4: width of the hall debounce count.
- STALL_W, 24: width of the stall timer; the timer saturates at 2^STALL_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  async active-high reset
- hall  in  3  {Ha,Hb,Hc}, asynchronous
- dir  in  1  1=forward, 0=reverse
- brake  in  1  active-high brake request, asynchronous
- i_limit  in  1  active-high over-current, asynchronous
- pwm  in  1  high-side enable from the PWM generator, synchronous to clk
- dead_time  in  DT_W  dead-time cycles; 0 means none
- db_len  in  DB_W  stable cycles required to accept a hall value
- fault_clr  in  1  one-cycle fault clear
- gate_hi  out  3  {A,B,C} high-side gates, 1=on
- gate_lo  out  3  {A,B,C} low-side gates, 1=on
- sector  out  3  currently accepted hall value
- hall_edge  out  1  one-cycle pulse on each accepted hall change
- stall  out  1  stall timer saturated
- fault  out  1  latched fault
- fault_code  out  2  00 none, 01 illegal hall, 10 over-current

Behaviour:
- Reset (async, rst=1) values:
  - gate_hi=0, gate_lo=0, sector=0, hall_edge=0, stall=0, fault=0, fault_code=0.
  - All phase FSMs go to OFF; all counters clear.
- Synchronisers: hall, brake and i_limit each pass through a 2-FF synchroniser. The synchronised values are used everywhere below.
- Debounce:
  - A candidate hall value is accepted when it has been stable for db_len+1 consecutive cycles and differs from sector.
  - On acceptance: sector updates and hall_edge pulses for 1 cycle.
  - db_len=0 accepts on the first cycle the value differs from sector.
- Commutation request, evaluated every cycle from the accepted sector (H=high on, L=low on):
  - Forward: 100 AH/CL, 110 BH/CL, 010 BH/AL, 011 CH/AL, 001 CH/BL, 101 AH/BL.
  - Reverse: 100 CH/AL, 110 CH/BL, 010 AH/BL, 011 AH/CL, 001 BH/CL, 101 BH/AL.
  - The unnamed phase is OFF.
- Request priority, highest first:
  1. fault latched: all phases OFF.
  2. i_limit: all phases OFF; this is cycle-by-cycle and also latches fault_code 10.
  3. brake: all phases LOW.
  4. Commutation table.
- Illegal hall: an accepted sector of 000 or 111 latches fault with fault_code 01.
- Fault latching:
  - fault=1 whenever fault_code≠0.
  - If several faults occur, the first one is held.
  - fault_clr clears fault only if the condition that caused it is currently absent. Otherwise fault_clr is ignored.
- Per-phase FSM with states OFF, DT, HIGH, LOW:
  - A request different from the current state forces the gates off immediately and moves the FSM to DT with a count of dead_time.
  - DT counts down and enters the requested state when the count reaches 0.
  - If the request changes during DT, the count restarts.
  - A request of OFF goes directly to OFF with no DT.
  - dead_time=0 skips DT; the phase changes in the next cycle.
- Gate outputs:
  - gate_hi[p] = (state==HIGH) & pwm.
  - gate_lo[p] = (state==LOW). Low-side gates are never PWM-gated.
  - Outputs are registered. By construction gate_hi[p] and gate_lo[p] are never both 1.
- Latency (dead_time=D, db_len=N): from a hall pin change to the new gate on is 2 sync + N+1 debounce + 1 request + D+1 cycles.
- Stall timer:
  - Increments every cycle while not braking and not faulted.
  - Clears on hall_edge.
  - Saturates at max and then asserts stall.
  - Stall is status only; it does not force gates off.
- dir change mid-rotation: the request changes immediately and each affected phase goes through DT.
- Reset mid-DT: the phase returns to OFF with gates at 0 asynchronously.

Decomposition:
- Shared package bldc_pkg:
  - Phase-state encoding (OFF/DT/HIGH/LOW).
  - Fault-code constants.
  - Forward and reverse commutation table constants.
  - Illegal-hall constants 000 and 111.
- Sub-module bldc_phase_dt: one phase FSM plus its dead-time counter, instantiated 3 times.

Test Plan:
1. Forward full rotation: dir=1, dead_time=4, db_len=2, pwm=1; drive hall 100→110→010→011→001→101 → gates follow the table, every transition shows ≥4 cycles with both gates of that phase off, and hall_edge pulses 6 times.
2. Debounce glitch: hall 100 held, with a 2-cycle glitch to 110 while db_len=3 → sector stays 100, no hall_edge, gates unchanged.
3. Illegal hall: hall=111 for 5 cycles → fault=1, fault_code=01, all gates 0. fault_clr while hall is still 111 → fault stays. Set hall=100 then fault_clr → fault=0, and AH then CL turns on after dead time.
4. Over-current: i_limit pulse of 3 cycles during sector 011 → gates 0 within 3 cycles of the pin edge, fault_code=10, and gates stay 0 after i_limit drops until fault_clr.
5. Brake and direction: brake=1 → gate_lo=111, gate_hi=000 after dead time. Release brake with dir=0 and sector 100 → CH/AL.
6. Stall and PWM: with STALL_W=4, hold hall constant → stall=1 after 15 cycles and clears on the next hall_edge. Toggle pwm → gate_hi follows pwm while gate_lo stays constant.
